// File: rtl/window_stats_engine_if.sv
// Corner-set / result handshake bundle for window_stats_engine.
// master = scan-window source and result consumer, slave = the engine.
interface window_stats_engine_if #(
    parameter int II_W = 32
);
    logic                in_valid;
    logic                in_ready;
    logic                in_mode;
    logic [II_W-1:0]     ii_tl;
    logic [II_W-1:0]     ii_tr;
    logic [II_W-1:0]     ii_bl;
    logic [II_W-1:0]     ii_br;
    logic [II_W-1:0]     sq_tl;
    logic [II_W-1:0]     sq_tr;
    logic [II_W-1:0]     sq_bl;
    logic [II_W-1:0]     sq_br;
    logic                out_valid;
    logic                out_ready;
    logic [2*II_W-1:0]   out_var;
    logic [II_W-1:0]     out_std;
    logic                out_sat;

    modport master (
        output in_valid, in_mode,
        output ii_tl, ii_tr, ii_bl, ii_br,
        output sq_tl, sq_tr, sq_bl, sq_br,
        output out_ready,
        input  in_ready, out_valid,
        input  out_var, out_std, out_sat
    );

    modport slave (
        input  in_valid, in_mode,
        input  ii_tl, ii_tr, ii_bl, ii_br,
        input  sq_tl, sq_tr, sq_bl, sq_br,
        input  out_ready,
        output in_ready, out_valid,
        output out_var, out_std, out_sat
    );
endinterface

// File: rtl/window_stats_engine.sv
// Window variance numerator V = N*SqSum - Sum^2 with optional
// bit-serial floor(sqrt(V)); one corner set in flight at a time.
module window_stats_engine #(
    parameter int WIN_SIZE = 24,
    parameter int II_W     = 32
) (
    input  logic clock,
    input  logic reset,
    window_stats_engine_if.slave bus
);
    localparam int N  = WIN_SIZE * WIN_SIZE;
    localparam int NW = $clog2(N + 1);
    localparam int VW = 2 * II_W;
    localparam int DW = VW + NW + 1;
    localparam int CW = $clog2(II_W);
    localparam logic [NW-1:0] N_BITS = NW'(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SQRT,
        DONE
    } state_t;

    state_t            state;
    logic [II_W-1:0]   sum_q;
    logic [II_W-1:0]   sqsum_q;
    logic              mode_q;
    logic [VW-1:0]     v_q;
    logic              sat_q;
    logic [VW-1:0]     rad_q;
    logic [II_W-1:0]   rem_q;
    logic [II_W-1:0]   root_q;
    logic [CW-1:0]     cnt_q;

    // N is a constant, so this folds into a handful of shifted adds.
    function automatic logic [DW-1:0] mul_n(input logic [II_W-1:0] x);
        logic [DW-1:0] acc;
        acc = '0;
        for (int i = 0; i < NW; i++) begin
            if (N_BITS[i]) acc = acc + (DW'(x) << i);
        end
        return acc;
    endfunction

    logic [DW-1:0]        nsq;
    logic [VW-1:0]        sq2;
    logic signed [DW-1:0] diff;
    logic [VW-1:0]        v_c;
    logic                 sat_c;

    always_comb begin
        nsq   = mul_n(sqsum_q);
        sq2   = {{II_W{1'b0}}, sum_q} * {{II_W{1'b0}}, sum_q};
        diff  = $signed(nsq) - $signed({{(DW-VW){1'b0}}, sq2});
        v_c   = diff[VW-1:0];
        sat_c = 1'b0;
        if (diff[DW-1]) begin
            v_c   = '0;
            sat_c = 1'b1;
        end else if (|diff[DW-2:VW]) begin
            v_c   = '1;
            sat_c = 1'b1;
        end
    end

    // Partial remainder stays below 2^II_W until the final step,
    // whose remainder is never reused.
    logic [II_W+1:0] rem_sh;
    logic [II_W+1:0] trial;
    logic            ge;
    logic [II_W-1:0] root_nx;

    always_comb begin
        rem_sh  = {rem_q, rad_q[VW-1:VW-2]};
        trial   = {root_q, 2'b01};
        ge      = (rem_sh >= trial);
        root_nx = {root_q[II_W-2:0], ge};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_var   <= '0;
            bus.out_std   <= '0;
            bus.out_sat   <= 1'b0;
            sum_q         <= '0;
            sqsum_q       <= '0;
            mode_q        <= 1'b0;
            v_q           <= '0;
            sat_q         <= 1'b0;
            rad_q         <= '0;
            rem_q         <= '0;
            root_q        <= '0;
            cnt_q         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sum_q   <= bus.ii_br - bus.ii_bl
                                 - bus.ii_tr + bus.ii_tl;
                        sqsum_q <= bus.sq_br - bus.sq_bl
                                 - bus.sq_tr + bus.sq_tl;
                        mode_q       <= bus.in_mode;
                        bus.in_ready <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    v_q   <= v_c;
                    sat_q <= sat_c;
                    if (mode_q) begin
                        bus.out_var   <= v_c;
                        bus.out_sat   <= sat_c;
                        bus.out_std   <= '0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        rad_q  <= v_c;
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt_q  <= CW'(II_W - 1);
                        state  <= SQRT;
                    end
                end
                SQRT: begin
                    rad_q  <= {rad_q[VW-3:0], 2'b00};
                    rem_q  <= II_W'(ge ? rem_sh - trial : rem_sh);
                    root_q <= root_nx;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        bus.out_var   <= v_q;
                        bus.out_sat   <= sat_q;
                        bus.out_std   <= root_nx;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_window_stats_engine.sv
// Scoreboard bench for window_stats_engine: directed cases with fixed
// expectations plus random corner sets checked against a reference model.
module tb_window_stats_engine;
    localparam int W    = 32;
    localparam int WIN  = 24;
    localparam int N    = WIN * WIN;
    localparam int LAT0 = W + 2;
    localparam int LAT1 = 2;

    typedef struct {
        logic [63:0] v;
        logic [31:0] s;
        logic        sat;
        int          acc;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    window_stats_engine_if #(.II_W(W)) bus ();

    window_stats_engine #(
        .WIN_SIZE(WIN),
        .II_W(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t exp_q[$];
    logic rand_rdy = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [65:0] lo;
        logic [65:0] hi;
        logic [65:0] mid;
        lo = 66'd0;
        hi = 66'h1_0000_0000;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= {2'b00, v}) lo = mid;
            else hi = mid;
        end
        return lo[31:0];
    endfunction

    function automatic exp_t model(
        input logic [31:0] tl, tr, bl, br,
        input logic [31:0] qtl, qtr, qbl, qbr,
        input logic mode
    );
        exp_t e;
        logic [31:0] s, q;
        logic signed [131:0] a, b, d;
        s = br - bl - tr + tl;
        q = qbr - qbl - qtr + qtl;
        a = q;
        b = s;
        d = a * N - b * b;
        if (d < 0) begin
            e.v = 64'd0;
            e.sat = 1'b1;
        end else if (d[131:64] != 0) begin
            e.v = '1;
            e.sat = 1'b1;
        end else begin
            e.v = d[63:0];
            e.sat = 1'b0;
        end
        e.s = mode ? 32'd0 : isqrt(e.v);
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] v, input logic [31:0] s,
                                input logic sat);
        exp_t e;
        e.v = v;
        e.s = s;
        e.sat = sat;
        e.acc = 0;
        e.lat = 0;
        return e;
    endfunction

    // Called and returns #1 after a rising edge.
    task automatic send(
        input logic [31:0] tl, tr, bl, br,
        input logic [31:0] qtl, qtr, qbl, qbr,
        input logic mode, input exp_t e, output int acc
    );
        bit got;
        got = 1'b0;
        acc = -1;
        bus.in_valid = 1'b1;
        bus.in_mode = mode;
        bus.ii_tl = tl; bus.ii_tr = tr; bus.ii_bl = bl; bus.ii_br = br;
        bus.sq_tl = qtl; bus.sq_tr = qtr; bus.sq_bl = qbl; bus.sq_br = qbr;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                got = 1'b1;
                acc = cyc;
                e.acc = cyc;
                e.lat = mode ? LAT1 : LAT0;
                exp_q.push_back(e);
            end
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_mode = $urandom_range(0, 1);
        bus.ii_tl = $urandom; bus.ii_tr = $urandom;
        bus.ii_bl = $urandom; bus.ii_br = $urandom;
        bus.sq_tl = $urandom; bus.sq_tr = $urandom;
        bus.sq_bl = $urandom; bus.sq_br = $urandom;
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: in_ready never seen (cycle %0d)",
                     cyc);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: compares every cycle out_valid is high, pops on handshake.
    initial begin
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: var %0h std %0h (cycle %0d)",
                             bus.out_var, bus.out_std, cyc);
                end else begin
                    e = exp_q[0];
                    if (!prev_v) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("out_var", bus.out_var, e.v);
                    chk("out_std", 64'(bus.out_std), 64'(e.s));
                    chk("out_sat", 64'(bus.out_sat), 64'(e.sat));
                    chk("in_ready_busy", 64'(bus.in_ready), 64'd0);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            prev_v = bus.out_valid && !reset;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int a;
        logic [31:0] s, q, tl, tr, bl, br, qtl, qtr, qbl, qbr;
        logic m;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_mode = 1'b0;
        bus.ii_tl = '0; bus.ii_tr = '0; bus.ii_bl = '0; bus.ii_br = '0;
        bus.sq_tl = '0; bus.sq_tr = '0; bus.sq_bl = '0; bus.sq_br = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_var", bus.out_var, 64'd0);
        chk("rst_out_std", 64'(bus.out_std), 64'd0);
        chk("rst_out_sat", 64'(bus.out_sat), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        send(0, 0, 0, 5760, 0, 0, 0, 57600, 1'b0, mk(0, 0, 0), a);
        send(0, 0, 0, 5760, 0, 0, 0, 115200, 1'b0,
             mk(64'd33177600, 32'd5760, 0), a);
        send(0, 0, 0, 5760, 0, 0, 0, 115200, 1'b1,
             mk(64'd33177600, 32'd0, 0), a);
        send(0, 0, 32'hFFFF_FFF0, 32'h0000_0010, 0, 0, 0, 1024, 1'b0,
             mk(64'd588800, 32'd767, 0), a);
        send(0, 0, 0, 100, 0, 0, 0, 0, 1'b0, mk(0, 0, 1), a);
        drain();

        // Back-pressure with a rejected second corner set.
        bus.out_ready = 1'b0;
        send(0, 0, 0, 5760, 0, 0, 0, 115200, 1'b0,
             mk(64'd33177600, 32'd5760, 0), a);
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.out_valid) break;
        end
        chk("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clock);
            #1;
            bus.in_valid = (i == 1);
            bus.in_mode = 1'b1;
            bus.ii_tl = 0; bus.ii_tr = 0;
            bus.ii_bl = 32'hFFFF_FFF0; bus.ii_br = 32'h10;
            bus.sq_tl = 0; bus.sq_tr = 0; bus.sq_bl = 0; bus.sq_br = 1024;
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("bp_valid_after", 64'(bus.out_valid), 64'd0);
        @(posedge clock);
        #1;
        send(0, 0, 32'hFFFF_FFF0, 32'h10, 0, 0, 0, 1024, 1'b1,
             mk(64'd588800, 32'd0, 0), a);
        drain();

        // Reset in cycle 10 of a mode-0 transaction.
        send(0, 0, 0, 5760, 0, 0, 0, 115200, 1'b0,
             mk(64'd33177600, 32'd5760, 0), a);
        for (int k = 0; k < 100 && cyc < a + 10; k++) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_out_var", bus.out_var, 64'd0);
        chk("mid_rst_out_std", 64'(bus.out_std), 64'd0);
        chk("mid_rst_out_sat", 64'(bus.out_sat), 64'd0);
        @(posedge clock);
        #1;
        send(0, 0, 0, 5760, 0, 0, 0, 115200, 1'b0,
             mk(64'd33177600, 32'd5760, 0), a);

        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 100000);
            q = $urandom;
            tl = $urandom; tr = $urandom; bl = $urandom;
            br = s + bl + tr - tl;
            qtl = $urandom; qtr = $urandom; qbl = $urandom;
            qbr = q + qbl + qtr - qtl;
            m = $urandom_range(0, 1);
            send(tl, tr, bl, br, qtl, qtr, qbl, qbr, m,
                 model(tl, tr, bl, br, qtl, qtr, qbl, qbr, m), a);
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/window_stats_engine.md
Name: window_stats_engine

Overview:
- Sequential, parametrised successor to the combinational window standard-deviation stage.
- Accepts the four integral-image corners and the four squared-integral-image corners of one scan window through a valid/ready handshake.
- Forms the scaled variance numerator V = N*SqSum - Sum^2, where N = WIN_SIZE^2.
- Returns either floor(sqrt(V)), computed by a bit-serial integer square root, or V itself, selected per transaction.
- Sits between the scan-window buffer and the classifier stage normaliser.

Parameters:
- WIN_SIZE, 24: window edge length in pixels; N = WIN_SIZE*WIN_SIZE.
- II_W, 32: width of every integral-image corner input. Result width of the std-dev output.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  corner set presented.
- in_ready  out  1  block can accept a corner set.
- in_mode  in  1  0 = std-dev (sqrt), 1 = raw variance numerator.
- ii_tl, ii_tr, ii_bl, ii_br  in  II_W each  integral-image corners.
- sq_tl, sq_tr, sq_bl, sq_br  in  II_W each  squared-integral-image corners.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_var  out  2*II_W  clamped V.
- out_std  out  II_W  floor(sqrt(clamped V)); 0 in variance mode.
- out_sat  out  1  V was clamped.

Behaviour:
- Reset (synchronous, active-high) has priority over everything, including mid-operation.
  - State returns to IDLE.
  - in_ready = 1; out_valid = 0; out_var = 0; out_std = 0; out_sat = 0.
  - All internal registers clear.
- Only one transaction is in flight at a time. in_ready = 1 only in state IDLE.
- FSM states: IDLE, CALC, SQRT, DONE.
- IDLE: on in_valid && in_ready, register the following and go to CALC:
  - Sum = ii_br - ii_bl - ii_tr + ii_tl, computed mod 2^II_W.
  - SqSum = sq_br - sq_bl - sq_tr + sq_tl, computed mod 2^II_W.
  - in_mode.
- Wrap-around is intended: integral images may overflow, and the corner difference is still exact provided the true window sum is below 2^II_W.
- CALC (exactly 1 cycle):
  - N*SqSum is formed exactly, as a constant shift-add.
  - Sum^2 is formed exactly in 2*II_W bits.
  - The difference is evaluated signed with enough width to be exact.
  - Negative difference: V = 0, out_sat = 1.
  - Difference above 2^(2*II_W) - 1: V = all-ones, out_sat = 1.
  - Otherwise V = the difference, out_sat = 0.
  - Next state: mode 0 goes to SQRT and loads the radicand; mode 1 goes to DONE with out_std = 0.
- SQRT: restoring digit-by-digit square root, one result bit per cycle, MSB first.
  - Exactly II_W cycles; then go to DONE.
  - Result is floor(sqrt(V)), exact for every V in [0, 2^(2*II_W) - 1].
- DONE: out_valid = 1.
  - out_var, out_std and out_sat hold stable for as long as out_ready = 0.
  - On out_ready = 1, go to IDLE. out_valid falls and in_ready rises the next cycle.
  - out_* keep their last value after the transaction until the next result is written.
- Latency, counting the accept cycle as cycle 0:
  - Mode 0: out_valid first high in cycle II_W+2 (34 at default).
  - Mode 1: out_valid first high in cycle 2.
- Throughput: one result per II_W+3 cycles in mode 0 with out_ready tied high.
- in_valid while in_ready = 0 is ignored. The source must hold its data; nothing is latched.
- in_* may change freely after acceptance.

Test Plan:
- Uniform window (defaults, N = 576): all pixels 10, so ii_br = 5760, sq_br = 57600, other corners 0, mode 0. Required: out_var = 0, out_std = 0, out_sat = 0, out_valid in cycle 34.
- Half-0/half-20 window: ii_br = 5760, sq_br = 115200, other corners 0.
  - Mode 0: out_var = 33177600, out_std = 5760.
  - Repeated in mode 1: out_var = 33177600, out_std = 0, out_valid in cycle 2.
- Corner wrap-around: ii_tl = 0, ii_tr = 0, ii_bl = 0xFFFFFFF0, ii_br = 0x00000010; sq_br = 1024, other sq corners 0. Required: Sum = 32, V = 576*1024 - 1024 = 588800, out_std = 767.
- Saturation: ii_br = 100, all sq corners 0. Required: out_var = 0, out_std = 0, out_sat = 1.
- Back-pressure: out_ready low for 5 cycles after out_valid rises, with a second in_valid pulse during that time. Required:
  - Outputs stable throughout; in_ready = 0 throughout; the second set is not accepted.
  - After out_ready is raised: in_ready = 1 the following cycle, and the second set is then accepted and produces the correct result.
- Reset mid-SQRT: assert reset in cycle 10 of a mode-0 transaction. Required: next cycle in IDLE, out_valid = 0, all outputs 0. A following transaction with ii_br = 5760, sq_br = 115200 returns out_std = 5760.
